// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared constants, FSM states and STATUS layout for uart_mmio_rx
// UART_RX_PARITY_EN adds the PARITY state to the receive FSM.
package uart_rx_pkg;

  localparam int BUS_WIDTH = 32;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int ST_IRQ       = 0;
  localparam int ST_OVERRUN   = 1;
  localparam int ST_FRAME_ERR = 2;
  localparam int ST_PARITY    = 3;
  localparam int ST_COUNT_LSB = 8;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;
`endif

endpackage

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - synchronous byte FIFO for received UART data
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [7:0]               i_push_data,
  input  logic                     i_pop,
  output logic [7:0]               o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_rx.sv
// rtl/uart_mmio_rx.sv - UART receiver with FIFO and DATA/STATUS read registers
// UART_RX_PARITY_EN selects 8E1 framing; default build is 8N1.
module uart_mmio_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 500000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 rd_en,
  input  logic                 rd_addr,
  output logic [BUS_WIDTH-1:0] rd_data,
  output logic                 rx_irq
);

  localparam int          CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int          CW           = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);

  logic                 r_rx_meta;
  logic                 r_rx_sync;
  logic                 r_rx_prev;
  rx_state_t            r_state;
  logic [15:0]          r_clk_cnt;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic                 r_par_bad;
  logic                 r_overrun;
  logic                 r_frame_err;
  logic                 r_parity_err;

  logic                 w_fall;
  logic                 w_bit_tick;
  logic                 w_push_req;
  logic                 w_stop_bad;
  logic                 w_par_event;
  logic                 w_data_rd;
  logic                 w_status_rd;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_set_overrun;
  logic [7:0]           w_head;
  logic [CW-1:0]        w_count;
  logic [BUS_WIDTH-1:0] w_status;

  // Synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall     = r_rx_prev & ~r_rx_sync;
  assign w_bit_tick = (r_clk_cnt == BIT_LAST);
  assign w_push_req = (r_state == S_STOP) & w_bit_tick & r_rx_sync & ~r_par_bad;
  assign w_stop_bad = (r_state == S_STOP) & w_bit_tick & ~r_rx_sync;
`ifdef UART_RX_PARITY_EN
  assign w_par_event = (r_state == S_PARITY) & w_bit_tick & (r_rx_sync != ^r_shift);
`else
  assign w_par_event = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
    end else begin
      r_clk_cnt <= r_clk_cnt + 16'd1;
      case (r_state)
        S_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
          r_par_bad <= 1'b0;
          if (w_fall) r_state <= S_START;
        end
        S_START: begin
          if (r_clk_cnt == HALF_LAST) begin
            r_clk_cnt <= '0;
            r_state   <= r_rx_sync ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_tick) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (r_bit_idx == 3'd7) r_state <= S_PARITY;
`else
            if (r_bit_idx == 3'd7) r_state <= S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_bit_tick) begin
            r_clk_cnt <= '0;
            r_par_bad <= (r_rx_sync != ^r_shift);
            r_state   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_tick) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_data_rd     = rd_en & (rd_addr == ADDR_DATA);
  assign w_status_rd   = rd_en & (rd_addr == ADDR_STATUS);
  assign w_pop         = w_data_rd & ~w_empty;
  assign w_set_overrun = w_push_req & w_full & ~w_pop;
  assign rx_irq        = ~w_empty;

  rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push_req),
    .i_push_data (r_shift),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  always_comb begin
    w_status                           = '0;
    w_status[ST_IRQ]                   = ~w_empty;
    w_status[ST_OVERRUN]               = r_overrun;
    w_status[ST_FRAME_ERR]             = r_frame_err;
    w_status[ST_PARITY]                = r_parity_err;
    w_status[ST_COUNT_LSB +: 8]        = 8'(w_count);
  end

  // A set event in the same cycle as a STATUS read keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      rd_data      <= '0;
    end else begin
      r_overrun    <= w_set_overrun | (r_overrun & ~w_status_rd);
      r_frame_err  <= w_stop_bad | (r_frame_err & ~w_status_rd);
      r_parity_err <= w_par_event | (r_parity_err & ~w_status_rd);
      if (w_data_rd)
        rd_data <= w_empty ? '0 : {{(BUS_WIDTH-8){1'b0}}, w_head};
      else if (w_status_rd)
        rd_data <= w_status;
    end
  end

endmodule

// File: tb/tb_uart_mmio_rx.sv
// tb/tb_uart_mmio_rx.sv - scoreboard bench for uart_mmio_rx
// Define UART_RX_PARITY_EN to exercise 8E1 framing.
module tb_uart_mmio_rx;

  localparam int CPB   = 100;
  localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        rx      = 1'b1;
  logic        rd_en   = 1'b0;
  logic        rd_addr = 1'b0;
  logic [31:0] rd_data;
  logic        rx_irq;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  sb[$];
  logic        m_overrun = 1'b0;
  logic        m_frame   = 1'b0;
  logic        m_parity  = 1'b0;

  always #10 clk = ~clk;

  uart_mmio_rx dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rx_irq  (rx_irq)
  );

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    idle_cycles(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    logic par_bad;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR_EN) drive_bit(par);
    drive_bit(stop);
    rx = 1'b1;
    par_bad = PAR_EN && (par != ^b);
    if (par_bad) m_parity = 1'b1;
    if (!stop) m_frame = 1'b1;
    if (stop && !par_bad) begin
      if (sb.size() < DEPTH) sb.push_back(b);
      else m_overrun = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, ^b, 1'b1);
  endtask

  task automatic bus_read(input logic a, output logic [31:0] d);
    rd_addr = a;
    rd_en   = 1'b1;
    @(negedge clk);
    rd_en   = 1'b0;
    d       = rd_data;
  endtask

  function automatic logic [31:0] exp_status();
    return {16'b0, 8'(sb.size()), 4'b0, m_parity, m_frame, m_overrun, (sb.size() != 0)};
  endfunction

  task automatic test_reset();
    logic [31:0] d, e;
    rst_n = 1'b0;
    idle_cycles(5);
    n_checks++;
    if (rd_data !== 32'h0) $display("FAIL reset_rd_data: got %h want 00000000", rd_data);
    else n_pass++;
    n_checks++;
    if (rx_irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", rx_irq);
    else n_pass++;
    rst_n = 1'b1;
    idle_cycles(5);
    e = exp_status();
    bus_read(1'b1, d);
    m_overrun = 0; m_frame = 0; m_parity = 0;
    n_checks++;
    if (d !== e) $display("FAIL reset_status: got %h want %h", d, e);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [31:0] d, e;
    int waited;
    send_byte(8'hA5);
    waited = 0;
    while (rx_irq !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (rx_irq !== 1'b1) $display("FAIL single_irq_rise: got %b want 1", rx_irq);
    else n_pass++;
    e = exp_status();
    bus_read(1'b1, d);
    m_overrun = 0; m_frame = 0; m_parity = 0;
    n_checks++;
    if (d !== e) $display("FAIL single_status: got %h want %h", d, e);
    else n_pass++;
    e = (sb.size() > 0) ? {24'b0, sb.pop_front()} : 32'h0;
    bus_read(1'b0, d);
    n_checks++;
    if (d !== e || e !== 32'h000000A5) $display("FAIL single_data: got %h want 000000a5", d);
    else n_pass++;
    n_checks++;
    if (rx_irq !== 1'b0) $display("FAIL single_irq_fall: got %b want 0", rx_irq);
    else n_pass++;
    idle_cycles(5);
    n_checks++;
    if (rd_data !== e) $display("FAIL single_hold: got %h want %h", rd_data, e);
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic [31:0] d, e;
    rx = 1'b0;
    idle_cycles(40);
    rx = 1'b1;
    idle_cycles(200);
    e = exp_status();
    bus_read(1'b1, d);
    m_overrun = 0; m_frame = 0; m_parity = 0;
    n_checks++;
    if (d !== e) $display("FAIL glitch_status: got %h want %h", d, e);
    else n_pass++;
  endtask

  task automatic test_frame_err();
    logic [31:0] d, e;
    send_frame(8'h3C, ^8'h3C, 1'b0);
    idle_cycles(200);
    for (int k = 0; k < 2; k++) begin
      e = exp_status();
      bus_read(1'b1, d);
      m_overrun = 0; m_frame = 0; m_parity = 0;
      n_checks++;
      if (d !== e) $display("FAIL frame_status%0d: got %h want %h", k, d, e);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back_overrun();
    logic [31:0] d, e;
    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    idle_cycles(20);
    e = exp_status();
    bus_read(1'b1, d);
    m_overrun = 0; m_frame = 0; m_parity = 0;
    n_checks++;
    if (d !== e) $display("FAIL overrun_status: got %h want %h", d, e);
    else n_pass++;
    for (int i = 0; i < 9; i++) begin
      e = (sb.size() > 0) ? {24'b0, sb.pop_front()} : 32'h0;
      bus_read(1'b0, d);
      n_checks++;
      if (d !== e) $display("FAIL overrun_data%0d: got %h want %h", i, d, e);
      else n_pass++;
    end
    e = exp_status();
    bus_read(1'b1, d);
    n_checks++;
    if (d !== e) $display("FAIL overrun_cleared: got %h want %h", d, e);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d, e;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    idle_cycles(50);
    rst_n = 1'b0;
    idle_cycles(10);
    rst_n = 1'b1;
    sb.delete();
    m_overrun = 0; m_frame = 0; m_parity = 0;
    idle_cycles(400);
    send_byte(8'h42);
    idle_cycles(20);
    e = exp_status();
    bus_read(1'b1, d);
    m_overrun = 0; m_frame = 0; m_parity = 0;
    n_checks++;
    if (d !== e) $display("FAIL midreset_status: got %h want %h", d, e);
    else n_pass++;
    e = (sb.size() > 0) ? {24'b0, sb.pop_front()} : 32'h0;
    bus_read(1'b0, d);
    n_checks++;
    if (d !== e || e !== 32'h00000042) $display("FAIL midreset_data: got %h want 00000042", d);
    else n_pass++;
    e = exp_status();
    bus_read(1'b1, d);
    n_checks++;
    if (d !== e) $display("FAIL midreset_empty: got %h want %h", d, e);
    else n_pass++;
  endtask

  task automatic test_parity();
    logic [31:0] d, e;
    send_frame(8'h07, 1'b0, 1'b1);
    idle_cycles(20);
    e = exp_status();
    bus_read(1'b1, d);
    m_overrun = 0; m_frame = 0; m_parity = 0;
    n_checks++;
    if (d !== e) $display("FAIL parity_bad_status: got %h want %h", d, e);
    else n_pass++;
    send_frame(8'h07, 1'b1, 1'b1);
    idle_cycles(20);
    e = exp_status();
    bus_read(1'b1, d);
    m_overrun = 0; m_frame = 0; m_parity = 0;
    n_checks++;
    if (d !== e) $display("FAIL parity_good_status: got %h want %h", d, e);
    else n_pass++;
    e = (sb.size() > 0) ? {24'b0, sb.pop_front()} : 32'h0;
    bus_read(1'b0, d);
    n_checks++;
    if (d !== e) $display("FAIL parity_good_data: got %h want %h", d, e);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back_overrun();
    test_reset_midframe();
    if (PAR_EN) test_parity();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_mmio_rx.md
UART_MMIO_RX -- requirements
Module: uart_mmio_rx

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 500000, serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (100 at defaults).
REQ-003 Parameter FIFO_DEPTH, default 8, receive FIFO entries; power of two, minimum 2.
REQ-004 Port clk  input  1  single system clock; all logic is on the rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port rx  input  1  serial line from the AVR (avr_tx); asynchronous; idles high.
REQ-007 Port rd_en  input  1  processor read strobe, one cycle per access.
REQ-008 Port rd_addr  input  1  0 = DATA register, 1 = STATUS register.
REQ-009 Port rd_data  output  32  read data; registered.
REQ-010 Port rx_irq  output  1  high while the FIFO is non-empty.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), and STOP.
REQ-013 IDLE->START on a synchronized 1->0 transition of rx.
REQ-014 START SHALL sample at CLKS_PER_BIT/2 cycles; if rx = 1, the FSM returns to IDLE (glitch reject); otherwise it goes to DATA.
REQ-015 DATA SHALL sample 8 bits, LSB first, each CLKS_PER_BIT cycles after the previous sample, then go to PARITY or STOP.
REQ-016 If STOP samples 1, the byte SHALL be pushed into the FIFO in the same cycle.
REQ-017 If STOP samples 0, the byte SHALL be discarded, sticky frame_err SHALL be set, and the FSM SHALL return to IDLE; a new start requires a fresh 1->0 edge.
REQ-018 A push while the FIFO is full SHALL drop the new byte and set sticky overrun; FIFO contents are unchanged.
REQ-019 A push and a DATA pop in the same cycle on a full FIFO SHALL accept the push with no overrun.
REQ-020 A DATA read (rd_en, rd_addr=0) SHALL return {24'b0, head byte} on rd_data in the next cycle and pop the FIFO; reading an empty FIFO SHALL return 0 with no pop.
REQ-021 A STATUS read SHALL return {16'b0, count[7:0], 4'b0, parity_err, frame_err, overrun, rx_irq} in the next cycle.
REQ-022 A STATUS read SHALL clear the three sticky bits; a set event in the same cycle wins, leaving the bit set.
REQ-023 rd_data SHALL hold its last value when rd_en is low.

Reset
REQ-024 When rst_n = 0: FSM in IDLE, FIFO empty, count 0, sticky bits 0, rd_data 0, rx_irq 0, synchronizer flops 1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no push; after release, reception restarts only on a new falling edge.

Configuration
REQ-026 With UART_RX_PARITY_EN defined, PARITY SHALL sample one even-parity bit after DATA.
REQ-027 On a parity mismatch, the byte SHALL be discarded and sticky parity_err set; the stop bit is still checked.
REQ-028 Without UART_RX_PARITY_EN the frame is 8N1, the PARITY state is absent, and STATUS bit 3 reads 0.

Structure
REQ-029 Shared package uart_rx_pkg SHALL hold BUS_WIDTH (32), the register offsets, the FSM state enum, and the STATUS bit positions.
REQ-030 The FIFO SHALL be the sub-module rx_fifo: synchronous, with push, pop, full, empty and count ports.

Verification
REQ-031 Send 0xA5 8N1 at 500000 baud -> rx_irq rises; STATUS count=1; DATA read returns 0x000000A5; rx_irq falls.
REQ-032 Apply a 40-cycle low glitch on idle rx -> no push; STATUS reads 0x00000000.
REQ-033 Send 0x3C with stop bit 0 -> frame_err=1, count=0; a second STATUS read returns frame_err=0.
REQ-034 Send 9 bytes 0x01..0x09 with no reads -> overrun=1; eight DATA reads return 0x01..0x08; a ninth returns 0.
REQ-035 Assert rst_n=0 during bit 4 of 0xFF, release, then send 0x42 -> only 0x42 is in the FIFO.
REQ-036 With UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> parity_err=1, count=0; send 0x07 with parity bit 1 -> accepted.
